// File: rtl/led_display_pkg.sv
// Shared types and helpers for the BCD display counter.
// Holds the decade type, the FSM state enum and BCD helper functions.
package led_display_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOAD
    } state_t;

    function automatic logic is_bcd(bcd_t v);
        return (v <= BCD_MAX);
    endfunction

    // Next value of one decade; shared by the digit register and by the
    // top level, which needs next-state digits for registered side outputs.
    function automatic bcd_t bcd_next(
        bcd_t q,
        logic clr,
        logic ld,
        bcd_t ld_val,
        logic cin
    );
        bcd_t n;
        n = q;
        if (clr) begin
            n = '0;
        end else if (ld) begin
            n = ld_val;
        end else if (cin) begin
            n = (q == BCD_MAX) ? '0 : q + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_display_counter_bcd_digit.sv
// Single BCD decade register with clear, load and carry chaining.
// Ports: clk, rstN, clr, ld, ld_val, cin in; q (decade), cout (carry) out.
module bcd_digit
    import led_display_pkg::*;
(
    input  logic clk,
    input  logic rstN,
    input  logic clr,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = bcd_next(q_q, clr, ld, ld_val, cin);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign cout = cin & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD up-counter stepped by rising edges of a slow tick.
// Ports: clk, rstN, tick_in, run, clear, load_valid, load_value in;
// load_ready, load_err, digits, wrap out; blank out when
// LEADING_ZERO_BLANK_EN is defined.
module bcd_display_counter
    import led_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    tick_in,
    input  logic                    run,
    input  logic                    clear,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic                    load_ready,
    output logic                    load_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    wrap
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank
`endif
);

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_STEP - 1);

    state_t          state_q, state_d;
    logic            tick_q;
    logic [7:0]      presc_q, presc_d;
    logic            load_ready_q;
    logic            load_err_q, load_err_d;
    logic            wrap_q, wrap_d;

    logic            edge_s;
    logic            all_bcd;
    logic            accept;
    logic            ld_ok;
    logic            adv;
    logic            step;
    logic [NUM_DIGITS:0] carry;

    always_comb begin
        all_bcd = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all_bcd &= is_bcd(load_value[4*i +: 4]);
        end
    end

    // Clear beats load beats step; an edge only counts while in RUN.
    always_comb begin
        edge_s = tick_in & ~tick_q;
        accept = load_valid & load_ready_q & ~clear;
        ld_ok  = accept & all_bcd;
        adv    = edge_s & (state_q == RUN) & ~clear & ~accept;
        step   = adv & (presc_q == PRESC_LAST);
    end

    always_comb begin
        presc_d = presc_q;
        if (clear || ld_ok) begin
            presc_d = '0;
        end else if (adv) begin
            presc_d = step ? 8'd0 : presc_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)   state_d = LOAD;
                else if (run) state_d = RUN;
            end
            RUN: begin
                if (accept)    state_d = LOAD;
                else if (!run) state_d = IDLE;
            end
            LOAD: begin
                state_d = run ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_err_d = accept & ~all_bcd;
        wrap_d     = carry[NUM_DIGITS];
    end

    // Edge register resets high so a tick already high at release is not
    // mistaken for a rising edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            tick_q       <= 1'b1;
            presc_q      <= '0;
            load_ready_q <= 1'b0;
            load_err_q   <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_in;
            presc_q      <= presc_d;
            load_ready_q <= (state_d != LOAD);
            load_err_q   <= load_err_d;
            wrap_q       <= wrap_d;
        end
    end

    assign carry[0] = step;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_digit u_digit (
            .clk    (clk),
            .rstN   (rstN),
            .clr    (clear),
            .ld     (ld_ok),
            .ld_val (load_value[4*g +: 4]),
            .cin    (carry[g]),
            .q      (digits[4*g +: 4]),
            .cout   (carry[g+1])
        );
    end

    assign load_ready = load_ready_q;
    assign load_err   = load_err_q;
    assign wrap       = wrap_q;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~(NUM_DIGITS)'(1);

    logic [NUM_DIGITS-1:0] blank_q, blank_d;

    // Derived from next-state digits so blank moves with digits.
    always_comb begin
        logic z;
        z       = 1'b1;
        blank_d = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            z &= (bcd_next(digits[4*i +: 4], clear, ld_ok,
                           load_value[4*i +: 4], carry[i]) == 4'd0);
            blank_d[i] = z;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            blank_q <= BLANK_RST;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed self-checking bench for bcd_display_counter.
// Instance a uses TICKS_PER_STEP=1, instance b uses TICKS_PER_STEP=3.
module tb_bcd_display_counter;

    logic        clk;
    logic        rstN;
    logic        tick_in;
    logic        run;
    logic        clear;
    logic        load_valid;
    logic [15:0] load_value;

    logic        load_ready_a, load_err_a, wrap_a;
    logic [15:0] digits_a;
    logic        load_ready_b, load_err_b, wrap_b;
    logic [15:0] digits_b;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]  blank_a, blank_b;
`endif

    int total = 0;
    int bad   = 0;
    logic wrap_seen;

    bcd_display_counter #(.NUM_DIGITS(4), .TICKS_PER_STEP(1)) dut_a (
        .clk        (clk),
        .rstN       (rstN),
        .tick_in    (tick_in),
        .run        (run),
        .clear      (clear),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready_a),
        .load_err   (load_err_a),
        .digits     (digits_a),
        .wrap       (wrap_a)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank      (blank_a)
`endif
    );

    bcd_display_counter #(.NUM_DIGITS(4), .TICKS_PER_STEP(3)) dut_b (
        .clk        (clk),
        .rstN       (rstN),
        .tick_in    (tick_in),
        .run        (run),
        .clear      (clear),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready_b),
        .load_err   (load_err_b),
        .digits     (digits_b),
        .wrap       (wrap_b)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank      (blank_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (wrap_a === 1'b1) wrap_seen = 1'b1;
    endtask

    task automatic pulse();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
    endtask

    initial begin
        rstN       = 1'b0;
        tick_in    = 1'b1;
        run        = 1'b1;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_value = 16'h0000;
        wrap_seen  = 1'b0;

        // Reset held with tick high
        cyc();
        cyc();
        chk("rst_digits", 32'(digits_a), 32'h0000);
        chk("rst_ready", 32'(load_ready_a), 32'd0);
        chk("rst_err", 32'(load_err_a), 32'd0);
        chk("rst_wrap", 32'(wrap_a), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        chk("rst_blank", 32'(blank_a), 32'hE);
`endif
        rstN = 1'b1;
        cyc();
        chk("ready_first", 32'(load_ready_a), 32'd1);
        chk("no_count_hi", 32'(digits_a), 32'h0000);
        cyc();
        chk("no_count_hi2", 32'(digits_a), 32'h0000);
        tick_in = 1'b0;
        cyc();

        // 12 edges, first one checked for latency
        tick_in = 1'b1;
        chk("pre_edge", 32'(digits_a), 32'h0000);
        cyc();
        chk("edge_lat", 32'(digits_a), 32'h0001);
        tick_in = 1'b0;
        cyc();
        for (int i = 0; i < 11; i++) pulse();
        chk("count12", 32'(digits_a), 32'h0012);
        chk("no_wrap12", 32'(wrap_seen), 32'd0);

        // Load 9998 and roll over
        load_value = 16'h9998;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        chk("ld9998", 32'(digits_a), 32'h9998);
        chk("ready_load", 32'(load_ready_a), 32'd0);
        chk("err_ok_load", 32'(load_err_a), 32'd0);
        cyc();
        chk("ready_back", 32'(load_ready_a), 32'd1);
        tick_in = 1'b1;
        cyc();
        chk("d9999", 32'(digits_a), 32'h9999);
        chk("wrap_pre", 32'(wrap_a), 32'd0);
        tick_in = 1'b0;
        cyc();
        tick_in = 1'b1;
        cyc();
        chk("d0000", 32'(digits_a), 32'h0000);
        chk("wrap_hi", 32'(wrap_a), 32'd1);
        tick_in = 1'b0;
        cyc();
        chk("wrap_lo", 32'(wrap_a), 32'd0);

        // Illegal load
        pulse();
        chk("d0001", 32'(digits_a), 32'h0001);
        load_value = 16'h12A4;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        chk("bad_err", 32'(load_err_a), 32'd1);
        chk("bad_ready", 32'(load_ready_a), 32'd0);
        chk("bad_keep", 32'(digits_a), 32'h0001);
        cyc();
        chk("bad_err_lo", 32'(load_err_a), 32'd0);
        chk("bad_ready_hi", 32'(load_ready_a), 32'd1);
        chk("bad_keep2", 32'(digits_a), 32'h0001);

        // Load beats coincident step
        load_value = 16'h0200;
        load_valid = 1'b1;
        tick_in    = 1'b1;
        cyc();
        load_valid = 1'b0;
        tick_in    = 1'b0;
        chk("ld_vs_step", 32'(digits_a), 32'h0200);
        cyc();
        cyc();
        chk("ld_vs_step2", 32'(digits_a), 32'h0200);

        // Edge during LOAD is dropped
        load_value = 16'h0100;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        tick_in    = 1'b1;
        cyc();
        tick_in    = 1'b0;
        cyc();
        chk("edge_in_load", 32'(digits_a), 32'h0100);

        // clear + load + edge together
        clear      = 1'b1;
        load_value = 16'h0500;
        load_valid = 1'b1;
        tick_in    = 1'b1;
        cyc();
        clear      = 1'b0;
        load_valid = 1'b0;
        tick_in    = 1'b0;
        chk("clr_a", 32'(digits_a), 32'h0000);
        chk("clr_b", 32'(digits_b), 32'h0000);
        chk("clr_noload", 32'(load_ready_a), 32'd1);
        chk("clr_noerr", 32'(load_err_a), 32'd0);
        cyc();

        // Prescaler held while stopped (instance b, 3 ticks per step)
        pulse();
        pulse();
        chk("b_two", 32'(digits_b), 32'h0000);
        chk("a_two", 32'(digits_a), 32'h0002);
        run = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) pulse();
        chk("b_stop", 32'(digits_b), 32'h0000);
        chk("a_stop", 32'(digits_a), 32'h0002);
        run = 1'b1;
        cyc();
        pulse();
        chk("b_step", 32'(digits_b), 32'h0001);
        chk("a_step", 32'(digits_a), 32'h0003);

        // Leading-zero pattern
        load_value = 16'h0040;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        chk("ld0040", 32'(digits_a), 32'h0040);
`ifdef LEADING_ZERO_BLANK_EN
        chk("blank0040", 32'(blank_a), 32'hC);
`endif
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
